// File: rtl/synth_pkg.sv
// Shared constants and types for the voice allocator and the phase bank it feeds.
//   NBANKS      : number of time-multiplexed voice slots
//   SLOT_W      : width of a slot index
//   AGE_W       : width of a per-slot age counter
//   MIDI_SILENT : note value that marks an unused slot
//   state_e     : allocator FSM encoding
package synth_pkg;

    localparam int unsigned NBANKS      = 10;
    localparam int unsigned SLOT_W      = $clog2(NBANKS);
    localparam int unsigned AGE_W       = 4;
    localparam logic [6:0]  MIDI_SILENT = 7'h00;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWrite
    } state_e;

endpackage

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
// Accepts note-on/note-off events over a valid/ready handshake, keeps a table of NBANKS
// voice slots with per-slot ages, and streams one slot's note per clk_en in the same
// round-robin order the phase bank walks.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   clk_en            : sample-rate enable, advances the output stream
//   i_evt_valid       : event present
//   i_evt_on          : 1 = note-on, 0 = note-off
//   i_evt_note        : MIDI note number
//   o_evt_ready       : allocator can accept an event
//   o_midi            : note for the current slot (0 = silent)
//   o_slot            : slot index currently presented on o_midi
//   o_frame           : high while o_slot == 0
//   o_voices          : number of non-silent slots
module voice_allocator #(
    parameter int unsigned NBANKS = synth_pkg::NBANKS,
    parameter int unsigned SLOT_W = synth_pkg::SLOT_W,
    parameter int unsigned AGE_W  = synth_pkg::AGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              i_evt_valid,
    input  logic              i_evt_on,
    input  logic [6:0]        i_evt_note,
    output logic              o_evt_ready,
    output logic [6:0]        o_midi,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_frame,
    output logic [SLOT_W-1:0] o_voices
);
    import synth_pkg::*;

    localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(NBANKS - 1);

    // Voice table and ages are flops so WRITE can compare every slot at once.
    logic [6:0]        table_q [NBANKS];
    logic [6:0]        table_d [NBANKS];
    logic [AGE_W-1:0]  age_q   [NBANKS];
    logic [AGE_W-1:0]  age_d   [NBANKS];

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              on_q, on_d;
    logic [6:0]        note_q, note_d;
    logic [SLOT_W-1:0] idx_q, idx_d;
    logic              match_found_q, match_found_d;
    logic [SLOT_W-1:0] match_idx_q, match_idx_d;
    logic              free_found_q, free_found_d;
    logic [SLOT_W-1:0] free_idx_q, free_idx_d;
    logic [SLOT_W-1:0] oldest_idx_q, oldest_idx_d;
    logic [AGE_W-1:0]  oldest_age_q, oldest_age_d;
    logic [SLOT_W-1:0] voices_q, voices_d;

    logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt;
    logic [6:0]        midi_q, midi_d;
    logic              frame_q, frame_d;

    logic              ready;
    logic [6:0]        scan_note;
    logic [SLOT_W-1:0] cnt;

    // Ready is held low until the first clock after reset release.
    assign ready = armed_q && (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        armed_d       = 1'b1;
        on_d          = on_q;
        note_d        = note_q;
        idx_d         = idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        oldest_idx_d  = oldest_idx_q;
        oldest_age_d  = oldest_age_q;
        voices_d      = voices_q;
        table_d       = table_q;
        age_d         = age_q;
        scan_note     = table_q[idx_q];
        cnt           = '0;

        unique case (state_q)
            StIdle: begin
                if (i_evt_valid && ready) begin
                    on_d          = i_evt_on;
                    note_d        = i_evt_note;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    oldest_idx_d  = '0;
                    oldest_age_d  = '0;
                    state_d       = StScan;
                end
            end

            StScan: begin
                if (!match_found_q && (scan_note == note_q)) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!free_found_q && (scan_note == MIDI_SILENT)) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                // Strict compare keeps the lowest index on an age tie.
                if (age_q[idx_q] > oldest_age_q) begin
                    oldest_age_d = age_q[idx_q];
                    oldest_idx_d = idx_q;
                end
                if (idx_q == LastSlot) begin
                    state_d = StWrite;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            StWrite: begin
                if (note_q != MIDI_SILENT) begin
                    if (on_q) begin
                        for (int i = 0; i < int'(NBANKS); i++) begin
                            if (match_found_q) begin
                                if (SLOT_W'(i) == match_idx_q) begin
                                    age_d[i] = '0;
                                end
                            end else if (free_found_q) begin
                                if (SLOT_W'(i) == free_idx_q) begin
                                    table_d[i] = note_q;
                                    age_d[i]   = '0;
                                end else if ((table_q[i] != MIDI_SILENT) && (age_q[i] != '1)) begin
                                    age_d[i] = age_q[i] + 1'b1;
                                end
                            end else begin
                                if (SLOT_W'(i) == oldest_idx_q) begin
                                    table_d[i] = note_q;
                                    age_d[i]   = '0;
                                end else if (age_q[i] != '1) begin
                                    age_d[i] = age_q[i] + 1'b1;
                                end
                            end
                        end
                    end else begin
                        for (int i = 0; i < int'(NBANKS); i++) begin
                            if (table_q[i] == note_q) begin
                                table_d[i] = MIDI_SILENT;
                                age_d[i]   = '0;
                            end
                        end
                    end
                end
                for (int i = 0; i < int'(NBANKS); i++) begin
                    if (table_d[i] != MIDI_SILENT) begin
                        cnt = cnt + 1'b1;
                    end
                end
                voices_d = cnt;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output stream: reads the registered table, so a same-cycle write is not yet visible.
    always_comb begin
        slot_nxt = (slot_q == LastSlot) ? '0 : slot_q + 1'b1;
        slot_d   = slot_q;
        midi_d   = midi_q;
        frame_d  = frame_q;
        if (clk_en) begin
            slot_d  = slot_nxt;
            midi_d  = table_q[slot_nxt];
            frame_d = (slot_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            armed_q       <= 1'b0;
            on_q          <= 1'b0;
            note_q        <= '0;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            oldest_idx_q  <= '0;
            oldest_age_q  <= '0;
            voices_q      <= '0;
            slot_q        <= LastSlot;
            midi_q        <= MIDI_SILENT;
            frame_q       <= 1'b0;
            for (int i = 0; i < int'(NBANKS); i++) begin
                table_q[i] <= MIDI_SILENT;
                age_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            on_q          <= on_d;
            note_q        <= note_d;
            idx_q         <= idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            oldest_idx_q  <= oldest_idx_d;
            oldest_age_q  <= oldest_age_d;
            voices_q      <= voices_d;
            slot_q        <= slot_d;
            midi_q        <= midi_d;
            frame_q       <= frame_d;
            for (int i = 0; i < int'(NBANKS); i++) begin
                table_q[i] <= table_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    assign o_evt_ready = ready;
    assign o_midi      = midi_q;
    assign o_slot      = slot_q;
    assign o_frame     = frame_q;
    assign o_voices    = voices_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed events, expected table kept by hand,
// stream and voice-count expectations queued and checked by a separate monitor.
module tb_voice_allocator;

    localparam int NB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic       evt_valid = 1'b0;
    logic       evt_on = 1'b0;
    logic [6:0] evt_note = 7'h00;
    logic       evt_ready;
    logic [6:0] midi;
    logic [3:0] slot;
    logic       frame;
    logic [3:0] voices;

    voice_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .i_evt_valid (evt_valid),
        .i_evt_on    (evt_on),
        .i_evt_note  (evt_note),
        .o_evt_ready (evt_ready),
        .o_midi      (midi),
        .o_slot      (slot),
        .o_frame     (frame),
        .o_voices    (voices)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         slot;
        logic [6:0] midi;
        logic       frame;
    } strm_t;

    int         total = 0;
    int         bad = 0;
    logic [6:0] exp_tab [NB];
    int         exp_slot = NB - 1;
    strm_t      strm_q [$];
    int         voice_q [$];
    logic       en_prev = 1'b0;
    logic       rdy_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) en_prev <= clk_en;

    // Monitor: stream word after every enabled edge, voice count when an event completes.
    always @(negedge clk) begin
        if (rst && en_prev) begin
            if (strm_q.size() == 0) begin
                check("stream_unexpected", 1, 0);
            end else begin
                strm_t e;
                e = strm_q.pop_front();
                check("stream_slot", int'(slot), e.slot);
                check("stream_midi", int'(midi), int'(e.midi));
                check("stream_frame", int'(frame), int'(e.frame));
            end
        end
        if (rst && evt_ready && !rdy_prev) begin
            if (voice_q.size() == 0) begin
                check("voices_unexpected", 1, 0);
            end else begin
                check("voices", int'(voices), voice_q.pop_front());
            end
        end
        rdy_prev = evt_ready;
    end

    task automatic step_stream(input int n);
        for (int k = 0; k < n; k++) begin
            strm_t e;
            exp_slot = (exp_slot == NB - 1) ? 0 : exp_slot + 1;
            e.slot   = exp_slot;
            e.midi   = exp_tab[exp_slot];
            e.frame  = (exp_slot == 0);
            strm_q.push_back(e);
            @(negedge clk) clk_en = 1'b1;
            @(negedge clk) clk_en = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        evt_valid = 1'b0;
        clk_en = 1'b0;
        #1;
        check("rst_slot", int'(slot), NB - 1);
        check("rst_midi", int'(midi), 0);
        check("rst_frame", int'(frame), 0);
        check("rst_voices", int'(voices), 0);
        check("rst_ready", int'(evt_ready), 0);
        @(negedge clk);
        check("rst_ready_held", int'(evt_ready), 0);
        for (int i = 0; i < NB; i++) exp_tab[i] = 7'h00;
        exp_slot = NB - 1;
        voice_q.push_back(0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(evt_ready), 1);
    endtask

    task automatic send_evt(input logic is_on, input logic [6:0] n, input int exp_voices);
        int cnt;
        cnt = 0;
        while (!evt_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("ready_before_evt", int'(evt_ready), 1);
        if (!evt_ready) return;
        voice_q.push_back(exp_voices);
        evt_valid = 1'b1;
        evt_on    = is_on;
        evt_note  = n;
        @(negedge clk);
        evt_valid = 1'b0;
        check("ready_low_after_accept", int'(evt_ready), 0);
        cnt = 1;
        while (!evt_ready && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("accept_spacing", cnt, NB + 2);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) exp_tab[i] = 7'h00;

        // Reset state and a silent frame 0..9.
        do_reset();
        step_stream(NB);

        // Single note lands in slot 0.
        send_evt(1'b1, 7'h45, 1);
        exp_tab[0] = 7'h45;
        step_stream(NB);

        // Fill all slots from a clean table, then steal the oldest (slot 0).
        do_reset();
        for (int k = 0; k < NB; k++) begin
            logic [6:0] n;
            n = 7'h3C + 7'(k);
            send_evt(1'b1, n, k + 1);
            exp_tab[k] = n;
        end
        step_stream(NB);
        send_evt(1'b1, 7'h50, NB);
        exp_tab[0] = 7'h50;
        step_stream(NB);

        // Note-off of a held note, then of an absent note.
        send_evt(1'b0, 7'h3E, NB - 1);
        exp_tab[2] = 7'h00;
        step_stream(NB);
        send_evt(1'b0, 7'h7F, NB - 1);
        step_stream(NB);

        // Note 0 is dropped; a duplicate retriggers without using a slot.
        send_evt(1'b1, 7'h00, NB - 1);
        send_evt(1'b1, 7'h45, NB - 1);
        step_stream(NB);

        // Free slot 2 is reused; next note steals slot 1 (age 10, the oldest).
        send_evt(1'b1, 7'h60, NB);
        exp_tab[2] = 7'h60;
        send_evt(1'b1, 7'h61, NB);
        exp_tab[1] = 7'h61;
        step_stream(NB);

        // Reset in the middle of a scan loses the event.
        @(negedge clk);
        check("ready_before_abort", int'(evt_ready), 1);
        evt_valid = 1'b1;
        evt_on    = 1'b1;
        evt_note  = 7'h40;
        @(negedge clk);
        evt_valid = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        step_stream(NB);
        send_evt(1'b1, 7'h30, 1);
        exp_tab[0] = 7'h30;
        step_stream(NB);

        repeat (4) @(negedge clk);
        check("stream_queue_drained", strm_q.size(), 0);
        check("voice_queue_drained", voice_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
